avalon_st_packet_fifo: RTL and testbench

Parametrised Avalon-ST FIFO and next-generation timing-adapter buffer with configurable data width and depth. It carries packet sideband (SOP/EOP/empty) and provides fill level, almost-full/almost-empty flags and synchronous flush. An optional store-and-forward packet mode holds output until a complete packet is buffered. It sits between Avalon-ST adapters and the Ethernet MAC/DMA paths, replacing fixed-size single-purpose FIFOs.

---
 rtl/avalon_st_fifo_pkg.sv | 21 ++
 rtl/avalon_st_fifo_ram.sv | 23 ++
 rtl/avalon_st_packet_fifo.sv | 104 ++++++++++
 tb/tb_avalon_st_packet_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_fifo_pkg.sv
// avalon_st_fifo_pkg: shared helpers and sideband-word layout for the Avalon-ST packet FIFO
package avalon_st_fifo_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int off_empty(input int dw);
    return dw;
  endfunction
  function automatic int off_sop(input int dw, input int ew);
    return dw + ew;
  endfunction
  function automatic int off_eop(input int dw, input int ew);
    return dw + ew + 1;
  endfunction
  function automatic int word_width(input int dw, input int ew);
    return dw + ew + 2;
  endfunction
endpackage

// File: rtl/avalon_st_fifo_ram.sv
// avalon_st_fifo_ram: simple dual-port RAM with one write port and a registered read port
module avalon_st_fifo_ram #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write port; the array carries no reset so it can map onto block RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read; a same-edge write is not forwarded, the old word is returned
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/avalon_st_packet_fifo.sv
// avalon_st_packet_fifo: Avalon-ST FIFO with packet sideband, fill flags, flush and store-and-forward mode
module avalon_st_packet_fifo
  import avalon_st_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int EMPTY_WIDTH = 2,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int PKT_MODE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic [ADDR_WIDTH:0]    fill_level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   oversize_err
);
  localparam int W = word_width(DATA_WIDTH, EMPTY_WIDTH);
  localparam int E0 = off_empty(DATA_WIDTH);
  localparam int S0 = off_sop(DATA_WIDTH, EMPTY_WIDTH);
  localparam int P0 = off_eop(DATA_WIDTH, EMPTY_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL_LVL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, rd_next, pkt_count, pkt_next;
  logic live, rls, rls_set, rls_next, full, push, pop, eop_in, eop_out, avail, gate, ov_next;
  logic [W-1:0] wdata, rdata;
  assign fill_level = wr_ptr - rd_ptr;
  assign full = fill_level == FULL_LVL;
  assign in_ready = live && !full && !flush;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign almost_full = fill_level >= AF_LVL;
  assign almost_empty = fill_level <= AE_LVL;
  assign wdata = {in_endofpacket, in_startofpacket, in_empty, in_data};
  assign out_data = rdata[DATA_WIDTH-1:0];
  assign out_empty = rdata[E0 +: EMPTY_WIDTH];
  assign out_startofpacket = rdata[S0];
  assign out_endofpacket = rdata[P0];
  // read-address prefetch, packet accounting, oversize release and the next output-valid
  always_comb begin
    rd_next = rd_ptr + {{ADDR_WIDTH{1'b0}}, pop};
    eop_in = push && in_endofpacket;
    eop_out = pop && out_endofpacket;
    pkt_next = (eop_in && !eop_out) ? pkt_count + ONE : (eop_out && !eop_in) ? pkt_count - ONE : pkt_count;
    rls_set = PKT_MODE != 0 && full && pkt_count == '0 && !rls;
    rls_next = rls_set ? 1'b1 : eop_out ? 1'b0 : rls;
    avail = fill_level > {{ADDR_WIDTH{1'b0}}, pop};
    gate = PKT_MODE == 0 || pkt_next != '0 || rls_next;
    ov_next = avail && gate;
  end
  // pointer, packet-count and output-valid state; flush clears everything but memory
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_count <= '0;
      rls <= 1'b0;
      out_valid <= 1'b0;
      oversize_err <= 1'b0;
      live <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_count <= '0;
      rls <= 1'b0;
      out_valid <= 1'b0;
      oversize_err <= 1'b0;
      live <= 1'b1;
    end else begin
      wr_ptr <= push ? wr_ptr + ONE : wr_ptr;
      rd_ptr <= rd_next;
      pkt_count <= PKT_MODE != 0 ? pkt_next : '0;
      rls <= rls_next;
      out_valid <= ov_next;
      oversize_err <= rls_set;
      live <= 1'b1;
    end
  avalon_st_fifo_ram #(.WIDTH(W), .DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .reset(reset),
    .we(push),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(wdata),
    .raddr(rd_next[ADDR_WIDTH-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_avalon_st_packet_fifo.sv
// tb_avalon_st_packet_fifo: scoreboard bench for cut-through (a_) and store-and-forward (b_) instances
module tb_avalon_st_packet_fifo;
  localparam int DW = 36;
  localparam int EW = 2;
  localparam int WW = DW + EW + 2;
  logic clk = 0, reset = 0, flush = 0, in_valid = 0, in_sop = 0, in_eop = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_empty = '0;
  logic a_in_ready, a_out_valid, a_sop, a_eop, a_af, a_ae, a_err;
  logic b_in_ready, b_out_valid, b_sop, b_eop, b_af, b_ae, b_err;
  logic [DW-1:0] a_data, b_data;
  logic [EW-1:0] a_empty, b_empty;
  logic [4:0] a_fill, b_fill;
  logic [WW-1:0] qa[$], qb[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  avalon_st_packet_fifo #(.PKT_MODE(0)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_ready(a_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(a_out_valid), .out_data(a_data), .out_startofpacket(a_sop),
    .out_endofpacket(a_eop), .out_empty(a_empty), .fill_level(a_fill), .almost_full(a_af),
    .almost_empty(a_ae), .oversize_err(a_err)
  );
  avalon_st_packet_fifo #(.PKT_MODE(1)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_ready(b_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(b_out_valid), .out_data(b_data), .out_startofpacket(b_sop),
    .out_endofpacket(b_eop), .out_empty(b_empty), .fill_level(b_fill), .almost_full(b_af),
    .almost_empty(b_ae), .oversize_err(b_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    in_valid = 0;
    in_sop = 0;
    in_eop = 0;
    in_empty = '0;
    in_data = '0;
    flush = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    out_ready = 0;
    qa.delete();
    qb.delete();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    tick();
  endtask
  task automatic test_reset();
    #1 reset = 1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_fill !== 5'd0) begin failures++; $display("FAIL rst_fill got=%0d exp=0", a_fill); end
    checks++; if (a_ae !== 1'b1) begin failures++; $display("FAIL rst_almost_empty got=%b exp=1", a_ae); end
    checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL rst_almost_full got=%b exp=0", a_af); end
    checks++; if (a_data !== '0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", a_data); end
    checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL rst_oversize got=%b exp=0", b_err); end
    @(posedge clk);
    #1 reset = 0;
    tick();
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", a_in_ready); end
  endtask
  task automatic test_fill();
    logic e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      in_data = DW'(i);
      @(negedge clk);
      checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready beat=%0d got=%b exp=1", i, a_in_ready); end
      qa.push_back({1'b0, 1'b0, 2'b00, in_data});
      tick();
      e = (i + 1 >= 12);
      checks++; if (a_fill !== 5'(i + 1)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", a_fill, i + 1); end
      checks++; if (a_af !== e) begin failures++; $display("FAIL fill_almost_full level=%0d got=%b exp=%b", i + 1, a_af, e); end
    end
    in_data = DW'(16);
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", a_in_ready); end
    tick();
    checks++; if (a_fill !== 5'd16) begin failures++; $display("FAIL full_no_accept got=%0d exp=16", a_fill); end
    in_valid = 0;
  endtask
  task automatic test_back_to_back();
    int nxt, pops;
    logic [WW-1:0] exp;
    nxt = 16;
    pops = 0;
    out_ready = 1;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1;
      in_data = DW'(nxt);
      @(negedge clk);
      if (a_in_ready) begin qa.push_back({4'b0000, in_data}); nxt++; end
      checks++; if (a_fill < 5'd15 || a_fill > 5'd16) begin failures++; $display("FAIL b2b_fill got=%0d exp=15..16", a_fill); end
      if (a_out_valid) begin
        pops++;
        exp = qa.size() > 0 ? qa.pop_front() : 'x;
        checks++; if ({a_eop, a_sop, a_empty, a_data} !== exp) begin failures++; $display("FAIL b2b_data got=%0h exp=%0h", {a_eop, a_sop, a_empty, a_data}, exp); end
      end
      tick();
    end
    checks++; if (pops != 40) begin failures++; $display("FAIL b2b_rate got=%0d exp=40", pops); end
    in_valid = 0;
    for (int c = 0; c < 40 && qa.size() > 0; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        exp = qa.pop_front();
        checks++; if ({a_eop, a_sop, a_empty, a_data} !== exp) begin failures++; $display("FAIL drain_data got=%0h exp=%0h", {a_eop, a_sop, a_empty, a_data}, exp); end
      end
      tick();
    end
    checks++; if (qa.size() != 0) begin failures++; $display("FAIL drain_left got=%0d exp=0", qa.size()); end
    checks++; if (a_fill !== 5'd0) begin failures++; $display("FAIL drain_fill got=%0d exp=0", a_fill); end
    out_ready = 0;
  endtask
  task automatic test_first_word();
    do_reset();
    in_valid = 1;
    in_data = 36'hA;
    tick();
    in_valid = 0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fw_early_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_fill !== 5'd1) begin failures++; $display("FAIL fw_fill got=%0d exp=1", a_fill); end
    tick();
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL fw_valid got=%b exp=1", a_out_valid); end
    checks++; if (a_data !== 36'hA) begin failures++; $display("FAIL fw_data got=%0h exp=a", a_data); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++; if (a_fill !== 5'd0) begin failures++; $display("FAIL fw_pop_fill got=%0d exp=0", a_fill); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fw_pop_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_ae !== 1'b1) begin failures++; $display("FAIL fw_almost_empty got=%b exp=1", a_ae); end
  endtask
  task automatic test_pkt_hold();
    logic [WW-1:0] exp;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = DW'(32'h100 + i);
      in_sop = (i == 0);
      in_eop = (i == 3);
      in_empty = (i == 3) ? 2'd2 : 2'd0;
      @(negedge clk);
      checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL pkt_hold beat=%0d got=%b exp=0", i, b_out_valid); end
      checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL pkt_ready beat=%0d got=%b exp=1", i, b_in_ready); end
      qb.push_back({in_eop, in_sop, in_empty, in_data});
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 20 && qb.size() > 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (b_out_valid !== 1'b1) begin failures++; $display("FAIL pkt_release got=%b exp=1", b_out_valid); end
      end
      if (b_out_valid) begin
        exp = qb.pop_front();
        checks++; if ({b_eop, b_sop, b_empty, b_data} !== exp) begin failures++; $display("FAIL pkt_data got=%0h exp=%0h", {b_eop, b_sop, b_empty, b_data}, exp); end
        if (b_eop === 1'b1) begin
          checks++; if (b_empty !== 2'd2) begin failures++; $display("FAIL pkt_empty got=%0d exp=2", b_empty); end
        end
      end
      tick();
    end
    checks++; if (qb.size() != 0) begin failures++; $display("FAIL pkt_left got=%0d exp=0", qb.size()); end
    out_ready = 0;
  endtask
  task automatic test_oversize();
    int k, errs, pops;
    logic [WW-1:0] exp;
    do_reset();
    out_ready = 1;
    k = 0;
    errs = 0;
    pops = 0;
    for (int c = 0; c < 120 && (k < 20 || qb.size() > 0); c++) begin
      in_valid = (k < 20);
      in_data = DW'(32'h200 + k);
      in_sop = (k == 0);
      in_eop = (k == 19);
      in_empty = 2'd1;
      @(negedge clk);
      if (in_valid && b_in_ready) begin qb.push_back({in_eop, in_sop, in_empty, in_data}); k++; end
      if (b_err) begin
        errs++;
        checks++; if (b_fill !== 5'd16) begin failures++; $display("FAIL ovs_fill got=%0d exp=16", b_fill); end
      end
      if (b_out_valid) begin
        pops++;
        exp = qb.size() > 0 ? qb.pop_front() : 'x;
        checks++; if ({b_eop, b_sop, b_empty, b_data} !== exp) begin failures++; $display("FAIL ovs_data got=%0h exp=%0h", {b_eop, b_sop, b_empty, b_data}, exp); end
      end
      tick();
    end
    idle_inputs();
    checks++; if (errs != 1) begin failures++; $display("FAIL ovs_err_count got=%0d exp=1", errs); end
    checks++; if (pops != 20) begin failures++; $display("FAIL ovs_beats got=%0d exp=20", pops); end
    in_valid = 1;
    in_data = DW'(32'h2AA);
    in_sop = 1;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL ovs_release_cleared got=%b exp=0", b_out_valid); end
      tick();
    end
    out_ready = 0;
  endtask
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = DW'(32'h300 + i);
      tick();
    end
    checks++; if (a_fill !== 5'd5) begin failures++; $display("FAIL fl_pre_fill got=%0d exp=5", a_fill); end
    flush = 1;
    in_data = DW'(32'h55);
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL fl_in_ready got=%b exp=0", a_in_ready); end
    tick();
    idle_inputs();
    checks++; if (a_fill !== 5'd0) begin failures++; $display("FAIL fl_fill got=%0d exp=0", a_fill); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", a_out_valid); end
    repeat (3) tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL fl_beat_absent got=%b exp=0", a_out_valid); end
    in_valid = 1;
    in_data = DW'(32'h66);
    tick();
    idle_inputs();
    tick();
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL fl_post_valid got=%b exp=1", a_out_valid); end
    checks++; if (a_data !== 36'h66) begin failures++; $display("FAIL fl_post_data got=%0h exp=66", a_data); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = DW'(32'h400 + i);
      tick();
    end
    in_valid = 1;
    #2 reset = 1;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_fill !== 5'd0) begin failures++; $display("FAIL ar_fill got=%0d exp=0", a_fill); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL ar_in_ready got=%b exp=0", a_in_ready); end
    checks++; if (a_ae !== 1'b1) begin failures++; $display("FAIL ar_almost_empty got=%b exp=1", a_ae); end
    checks++; if (a_data !== '0) begin failures++; $display("FAIL ar_data got=%0h exp=0", a_data); end
    idle_inputs();
    @(posedge clk);
    #1 reset = 0;
    tick();
  endtask
  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_first_word();
    test_pkt_hold();
    test_oversize();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
